mdu_ctrl: RTL and testbench

Multi-cycle multiply/divide unit with its own sequencer for the 5-stage MIPS pipeline. It sits in the E stage beside the ALU and owns the HI/LO registers. It executes mult/multu/div/divu, mthi/mtlo and mfhi/mflo. A busy counter models fixed latencies, and the block exports Start/Busy so the D-stage stall logic can hold later MDU instructions.

---
 rtl/mdu_ctrl.sv | 148 ++++++++++++++
 tb/tb_mdu_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer owning HI/LO for the E stage of the MIPS pipeline.
// Optional MDU_CANCEL_EN adds E_Cancel to flush an in-flight operation and suppress writes.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDUOp,
    input  logic [31:0] E_RS,
    input  logic [31:0] E_RT,
`ifdef MDU_CANCEL_EN
    input  logic        E_Cancel,
`endif
    output logic        E_Start,
    output logic        E_Busy,
    output logic [31:0] E_MDUOut,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [3:0]         op_q;
    logic [31:0]        op_a;
    logic [31:0]        op_b;
    logic               cancel;
    logic               is_start_op;

    logic signed [63:0] a_ext;
    logic signed [63:0] b_ext;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        divisor;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic [31:0]        quo_u;
    logic [31:0]        rem_u;

`ifdef MDU_CANCEL_EN
    assign cancel = E_Cancel;
`else
    assign cancel = 1'b0;
`endif

    assign is_start_op = (E_MDUOp >= OP_MULT) && (E_MDUOp <= OP_DIVU);
    assign E_Start     = (state == S_IDLE) && is_start_op && !cancel;

    always_comb begin
        E_MDUOut = 32'd0;
        case (E_MDUOp)
            OP_MFHI: E_MDUOut = HI;
            OP_MFLO: E_MDUOut = LO;
            default: E_MDUOut = 32'd0;
        endcase
    end

    // Divisor is forced non-zero so the datapath never produces X; a zero divide skips the write.
    always_comb begin
        a_ext   = {{32{op_a[31]}}, op_a};
        b_ext   = {{32{op_b[31]}}, op_b};
        prod_s  = a_ext * b_ext;
        prod_u  = {32'd0, op_a} * {32'd0, op_b};
        divisor = (op_b == 32'd0) ? 32'd1 : op_b;
        quo_s   = $signed(op_a) / $signed(divisor);
        rem_s   = $signed(op_a) % $signed(divisor);
        quo_u   = op_a / divisor;
        rem_u   = op_a % divisor;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            E_Busy <= 1'b0;
            HI     <= 32'd0;
            LO     <= 32'd0;
            op_q   <= 4'd0;
            op_a   <= 32'd0;
            op_b   <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (E_Start) begin
                        op_q   <= E_MDUOp;
                        op_a   <= E_RS;
                        op_b   <= E_RT;
                        cnt    <= (E_MDUOp <= OP_MULTU) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        state  <= S_RUN;
                        E_Busy <= 1'b1;
                    end else if (!cancel) begin
                        if (E_MDUOp == OP_MTHI) HI <= E_RS;
                        if (E_MDUOp == OP_MTLO) LO <= E_RS;
                    end
                end
                S_RUN: begin
                    if (cancel) begin
                        state  <= S_IDLE;
                        E_Busy <= 1'b0;
                        cnt    <= '0;
                    end else if (cnt == CNT_W'(1)) begin
                        case (op_q)
                            OP_MULT:  {HI, LO} <= prod_s;
                            OP_MULTU: {HI, LO} <= prod_u;
                            OP_DIV: begin
                                if (op_b != 32'd0) begin
                                    LO <= quo_s;
                                    HI <= rem_s;
                                end
                            end
                            OP_DIVU: begin
                                if (op_b != 32'd0) begin
                                    LO <= quo_u;
                                    HI <= rem_u;
                                end
                            end
                            default: ;
                        endcase
                        state  <= S_IDLE;
                        E_Busy <= 1'b0;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    E_Busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases plus random traffic against a cycle-count model.
module tb_mdu_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  e_op;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic        e_cancel;
    logic        E_Start;
    logic        E_Busy;
    logic [31:0] E_MDUOut;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int passes = 0;

    // Model: architectural HI/LO, cycles left in the current operation, and the pending result.
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    int          m_left;
    bit          p_write;

    mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk      (clk),
        .reset    (reset),
        .E_MDUOp  (e_op),
        .E_RS     (e_rs),
        .E_RT     (e_rt),
`ifdef MDU_CANCEL_EN
        .E_Cancel (e_cancel),
`endif
        .E_Start  (E_Start),
        .E_Busy   (E_Busy),
        .E_MDUOut (E_MDUOut),
        .HI       (HI),
        .LO       (LO)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic void issueModel(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
        longint          ps;
        longint unsigned pu;
        int              q, r;
        p_write = 1'b1;
        case (op)
            4'd1: begin ps = longint'($signed(rs)) * longint'($signed(rt)); {p_hi, p_lo} = ps; end
            4'd2: begin pu = 64'(rs) * 64'(rt); {p_hi, p_lo} = pu; end
            4'd3: begin
                if (rt == 0) p_write = 1'b0;
                else begin q = int'(rs) / int'(rt); r = int'(rs) % int'(rt); p_lo = q; p_hi = r; end
            end
            default: begin
                if (rt == 0) p_write = 1'b0;
                else begin p_lo = rs / rt; p_hi = rs % rt; end
            end
        endcase
        m_left = (op <= 4'd2) ? MULT_N : DIV_N;
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, then advance model and DUT.
    task automatic applyStimulus(input bit rst, input bit cancel, input logic [3:0] op,
                                 input logic [31:0] rs, input logic [31:0] rt);
        bit          exp_busy, exp_start, ce;
        logic [31:0] exp_out;
        reset = rst; e_cancel = cancel; e_op = op; e_rs = rs; e_rt = rt;
        #2;
`ifdef MDU_CANCEL_EN
        ce = cancel;
`else
        ce = 1'b0;
`endif
        exp_busy  = (m_left > 0);
        exp_start = !exp_busy && (op >= 4'd1) && (op <= 4'd4) && !ce;
        exp_out   = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
        if (exp_busy && (op >= 4'd1) && (op <= 4'd4) && !rst)
            $display("[TB] protocol error: MDU start issued while busy, design must ignore it");
        checkOutput("busy",  {31'd0, E_Busy},  {31'd0, exp_busy});
        checkOutput("start", {31'd0, E_Start}, {31'd0, exp_start});
        checkOutput("mduout", E_MDUOut, exp_out);
        checkOutput("hi", HI, m_hi);
        checkOutput("lo", LO, m_lo);
        if (rst) begin
            m_left = 0; m_hi = 0; m_lo = 0;
        end else if (m_left > 0) begin
            if (ce) m_left = 0;
            else begin
                m_left--;
                if (m_left == 0 && p_write) begin m_hi = p_hi; m_lo = p_lo; end
            end
        end else if (exp_start) begin
            issueModel(op, rs, rt);
        end else if (!ce) begin
            if (op == 4'd7) m_hi = rs;
            if (op == 4'd8) m_lo = rs;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 4'd0, $urandom, $urandom);
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; m_left = 0; p_write = 1'b0;
        reset = 1'b1; e_cancel = 1'b0; e_op = 4'd0; e_rs = 32'd0; e_rt = 32'd0;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b0, 4'd1, 32'h1111, 32'h2222);

        applyStimulus(1'b0, 1'b0, 4'd1, 32'hFFFFFFFD, 32'd5);
        idle(MULT_N);
        checkOutput("mult_hi", HI, 32'hFFFFFFFF);
        checkOutput("mult_lo", LO, 32'hFFFFFFF1);
        applyStimulus(1'b0, 1'b0, 4'd2, 32'hFFFFFFFD, 32'd5);
        idle(MULT_N);
        checkOutput("multu_hi", HI, 32'h00000004);
        checkOutput("multu_lo", LO, 32'hFFFFFFF1);

        applyStimulus(1'b0, 1'b0, 4'd3, 32'hFFFFFFF9, 32'd2);
        idle(DIV_N);
        checkOutput("div_lo", LO, 32'hFFFFFFFD);
        checkOutput("div_hi", HI, 32'hFFFFFFFF);
        applyStimulus(1'b0, 1'b0, 4'd4, 32'd7, 32'd2);
        idle(DIV_N);
        checkOutput("divu_lo", LO, 32'd3);
        checkOutput("divu_hi", HI, 32'd1);
        applyStimulus(1'b0, 1'b0, 4'd4, 32'd5, 32'd0);
        idle(DIV_N);
        checkOutput("div0_lo", LO, 32'd3);
        checkOutput("div0_hi", HI, 32'd1);

        applyStimulus(1'b0, 1'b0, 4'd7, 32'h12345678, 32'd0);
        checkOutput("mthi", HI, 32'h12345678);
        applyStimulus(1'b0, 1'b0, 4'd6, 32'd0, 32'd0);
        applyStimulus(1'b0, 1'b0, 4'd5, 32'd0, 32'd0);

        applyStimulus(1'b0, 1'b0, 4'd8, 32'h00000BAD, 32'd0);
        applyStimulus(1'b0, 1'b0, 4'd1, 32'd6, 32'd7);
        applyStimulus(1'b0, 1'b0, 4'd8, 32'h0000DEAD, 32'd0);
        checkOutput("mtlo_busy", LO, 32'h00000BAD);
        idle(MULT_N - 1);
        checkOutput("mult42_lo", LO, 32'd42);

        applyStimulus(1'b0, 1'b0, 4'd1, 32'd3, 32'd4);
        idle(1);
        applyStimulus(1'b0, 1'b0, 4'd1, 32'd100, 32'd100);
        idle(MULT_N - 1);
        checkOutput("sbusy_lo", LO, 32'd12);
        checkOutput("sbusy_hi", HI, 32'd0);

        applyStimulus(1'b0, 1'b0, 4'd3, 32'd100, 32'd7);
        idle(3);
        applyStimulus(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
        checkOutput("rst_busy", {31'd0, E_Busy}, 32'd0);
        checkOutput("rst_hi", HI, 32'd0);
        checkOutput("rst_lo", LO, 32'd0);

`ifdef MDU_CANCEL_EN
        applyStimulus(1'b0, 1'b0, 4'd7, 32'hA, 32'd0);
        applyStimulus(1'b0, 1'b0, 4'd8, 32'hB, 32'd0);
        applyStimulus(1'b0, 1'b0, 4'd3, 32'd100, 32'd7);
        idle(2);
        applyStimulus(1'b0, 1'b1, 4'd0, 32'd0, 32'd0);
        checkOutput("cancel_busy", {31'd0, E_Busy}, 32'd0);
        checkOutput("cancel_hi", HI, 32'hA);
        checkOutput("cancel_lo", LO, 32'hB);
        applyStimulus(1'b0, 1'b1, 4'd7, 32'h55, 32'd0);
        checkOutput("cancel_mthi", HI, 32'hA);
`endif

        // Random traffic obeying the stall rule: no new multiply/divide is issued while busy.
        for (int i = 0; i < 600; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
            if ($urandom_range(0, 1) == 1) rb = rb - 32'd2;
            if (m_left > 0 && rop >= 4'd1 && rop <= 4'd4) rop = 4'd0;
            if (rop == 4'd3 && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd1;
            applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 31) == 0), rop, ra, rb);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
